// File: rtl/const_def.sv
// -----------------------------------------------------------------------------
// const_def -- constants shared by the out-of-order core blocks.
//   TAG_W      rename-tag width
//   ROB_DEPTH  reorder-buffer entry count (live tags are 1..ROB_DEPTH)
//   TAG_NONE   tag value meaning "no dependency"
//   REG_ZERO   architectural register x0 (writes are ignored by the RF)
//   rob_state_e  reorder-buffer control state
// -----------------------------------------------------------------------------
package const_def;

  localparam int TAG_W     = 5;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_NONE  = 0;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ROB_RUN   = 1'b0,
    ROB_FLUSH = 1'b1
  } rob_state_e;

endpackage

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer -- circular in-order retirement queue between the dispatcher,
// the CDB and the architectural register file.
//
// Each dispatched instruction gets a rename tag (slot index + 1; tag 0 means
// "no dependency"). CDB writebacks mark entries ready; the head entry retires
// to the RF commit port one per cycle. A retiring branch whose resolved
// direction differs from its prediction commits normally, then the buffer
// spends one cycle in FLUSH, which empties it and raises flush/redirect_pc.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rdy                           global enable; 0 freezes all state/outputs
//   alloc_valid/rd/is_br/pred_taken/pc_alt   dispatcher allocation request
//   alloc_tag                     tag the next allocation receives
//   full                          registered count == DEPTH
//   cdb_valid/tag/data/br_taken   result writeback
//   q1_tag,q2_tag -> q*_ready,q*_data   operand bypass lookups
//   commit_valid/rd/tag/data      registered RF write port
//   flush, redirect_pc            registered pipeline flush + fetch target
//
// Build option: define ROB_BYPASS_EN to enable the q1/q2 lookup; otherwise the
// lookup outputs are tied to 0 and the ports are kept for interface stability.
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int DEPTH = const_def::ROB_DEPTH,
  parameter int TAG_W = const_def::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_is_br,
  input  logic             alloc_pred_taken,
  input  logic [31:0]      alloc_pc_alt,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             cdb_br_taken,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_data,
  output logic [31:0]      q2_data,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_data,
  output logic             flush,
  output logic [31:0]      redirect_pc
);
  import const_def::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Queue pointers and control
  logic [IDX_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full_reg;
  rob_state_e       state_reg;

  // Entry storage
  logic [DEPTH-1:0] busy_reg, ready_reg, is_br_reg, pred_reg, taken_reg;
  logic [4:0]       rd_reg     [DEPTH];
  logic [31:0]      pc_alt_reg [DEPTH];
  logic [31:0]      data_reg   [DEPTH];

  // Registered outputs
  logic             commit_valid_reg, flush_reg;
  logic [4:0]       commit_rd_reg;
  logic [TAG_W-1:0] commit_tag_reg;
  logic [31:0]      commit_data_reg, redirect_pc_reg;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic tag_live(input logic [TAG_W-1:0] tag);
    return (tag != TAG_W'(TAG_NONE)) && (tag <= TAG_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] tag);
    logic [TAG_W-1:0] slot;
    slot = tag - TAG_W'(1);
    return slot[IDX_W-1:0];
  endfunction

  logic [IDX_W-1:0] cdb_idx;
  logic             alloc_fire, cdb_fire, commit_fire, mispredict;

  assign cdb_idx = tag_idx(cdb_tag);

  // Allocation also waits out the flush-output cycle so wrong-path dispatches
  // still in flight cannot land in the freshly emptied queue.
  assign alloc_fire  = rdy && alloc_valid && !full_reg && !flush_reg && (state_reg == ROB_RUN);
  assign cdb_fire    = rdy && cdb_valid && tag_live(cdb_tag) && busy_reg[cdb_idx];
  assign commit_fire = rdy && (state_reg == ROB_RUN) && busy_reg[head_reg] && ready_reg[head_reg];
  assign mispredict  = is_br_reg[head_reg] && (taken_reg[head_reg] != pred_reg[head_reg]);

  always_comb begin
    count_next = count_reg;
    if (alloc_fire && !commit_fire)
      count_next = count_reg + CNT_W'(1);
    else if (!alloc_fire && commit_fire)
      count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      state_reg        <= ROB_RUN;
      busy_reg         <= '0;
      ready_reg        <= '0;
      commit_valid_reg <= 1'b0;
      commit_rd_reg    <= REG_ZERO;
      commit_tag_reg   <= '0;
      commit_data_reg  <= '0;
      flush_reg        <= 1'b0;
      redirect_pc_reg  <= '0;
    end else if (rdy) begin
      commit_valid_reg <= 1'b0;
      flush_reg        <= 1'b0;
      if (state_reg == ROB_FLUSH) begin
        // Empty the queue; redirect_pc was captured when the branch retired.
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
        full_reg  <= 1'b0;
        busy_reg  <= '0;
        ready_reg <= '0;
        flush_reg <= 1'b1;
        state_reg <= ROB_RUN;
      end else begin
        if (cdb_fire) begin
          ready_reg[cdb_idx] <= 1'b1;
          data_reg[cdb_idx]  <= cdb_data;
          taken_reg[cdb_idx] <= cdb_br_taken;
        end
        if (alloc_fire) begin
          busy_reg[tail_reg]   <= 1'b1;
          ready_reg[tail_reg]  <= 1'b0;
          rd_reg[tail_reg]     <= alloc_rd;
          is_br_reg[tail_reg]  <= alloc_is_br;
          pred_reg[tail_reg]   <= alloc_pred_taken;
          pc_alt_reg[tail_reg] <= alloc_pc_alt;
          tail_reg             <= wrap_inc(tail_reg);
        end
        if (commit_fire) begin
          busy_reg[head_reg] <= 1'b0;
          commit_valid_reg   <= 1'b1;
          commit_rd_reg      <= rd_reg[head_reg];
          commit_tag_reg     <= TAG_W'(head_reg) + TAG_W'(1);
          commit_data_reg    <= data_reg[head_reg];
          head_reg           <= wrap_inc(head_reg);
          if (mispredict) begin
            state_reg       <= ROB_FLUSH;
            redirect_pc_reg <= pc_alt_reg[head_reg];
          end
        end
        count_reg <= count_next;
        // Registered full: a same-cycle commit cannot admit an allocation.
        full_reg  <= (count_next == CNT_W'(DEPTH));
      end
    end
  end

  assign alloc_tag    = TAG_W'(tail_reg) + TAG_W'(1);
  assign full         = full_reg;
  assign commit_valid = commit_valid_reg;
  assign commit_rd    = commit_rd_reg;
  assign commit_tag   = commit_tag_reg;
  assign commit_data  = commit_data_reg;
  assign flush        = flush_reg;
  assign redirect_pc  = redirect_pc_reg;

`ifdef ROB_BYPASS_EN
  // Reads current state only; a same-cycle CDB result is not forwarded.
  logic [IDX_W-1:0] q1_idx, q2_idx;
  assign q1_idx   = tag_idx(q1_tag);
  assign q2_idx   = tag_idx(q2_tag);
  assign q1_ready = tag_live(q1_tag) && busy_reg[q1_idx] && ready_reg[q1_idx];
  assign q2_ready = tag_live(q2_tag) && busy_reg[q2_idx] && ready_reg[q2_idx];
  assign q1_data  = tag_live(q1_tag) ? data_reg[q1_idx] : 32'd0;
  assign q2_data  = tag_live(q2_tag) ? data_reg[q2_idx] : 32'd0;
`else
  logic unused_q_tags;
  assign unused_q_tags = ^{q1_tag, q2_tag};
  assign q1_ready = 1'b0;
  assign q2_ready = 1'b0;
  assign q1_data  = 32'd0;
  assign q2_data  = 32'd0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer -- directed scenarios plus randomized traffic for
// reorder_buffer, checked every cycle against an in-order queue model.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, rdy;
  logic             alloc_valid, alloc_is_br, alloc_pred_taken;
  logic [4:0]       alloc_rd;
  logic [31:0]      alloc_pc_alt;
  logic [TAG_W-1:0] alloc_tag;
  logic             full;
  logic             cdb_valid, cdb_br_taken;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic [TAG_W-1:0] q1_tag, q2_tag;
  logic             q1_ready, q2_ready;
  logic [31:0]      q1_data, q2_data;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [TAG_W-1:0] commit_tag;
  logic [31:0]      commit_data;
  logic             flush;
  logic [31:0]      redirect_pc;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_br(alloc_is_br),
    .alloc_pred_taken(alloc_pred_taken), .alloc_pc_alt(alloc_pc_alt),
    .alloc_tag(alloc_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_br_taken(cdb_br_taken),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush), .redirect_pc(redirect_pc)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: an in-order list of live entries ----
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          is_br, pred, rdy_f, taken;
    logic [31:0] pc_alt, data;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;            // tag the next allocation gets
  bit          m_full, m_flush, m_fpend, m_cv;
  logic [4:0]  m_crd;
  int          m_ctag;
  logic [31:0] m_cdata, m_redir;

  task automatic m_reset();
    mq.delete();
    m_tail = 1; m_full = 0; m_flush = 0; m_fpend = 0; m_cv = 0;
    m_crd = 0; m_ctag = 0; m_cdata = 0; m_redir = 0;
  endtask

  function automatic bit is_live(input int t);
    foreach (mq[i]) if (mq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void lookup(input logic [TAG_W-1:0] t, output bit r, output logic [31:0] d);
    r = 1'b0;
    d = 32'd0;
`ifdef ROB_BYPASS_EN
    foreach (mq[i]) if (mq[i].tag == int'(t) && mq[i].rdy_f) begin
      r = 1'b1;
      d = mq[i].data;
    end
`endif
  endfunction

  always @(posedge clk) begin : model_p
    bit   do_commit, was_flush;
    ent_t e;
    if (rst) m_reset();
    else if (rdy) begin
      was_flush = m_flush;
      m_cv = 0;
      m_flush = 0;
      if (m_fpend) begin
        mq.delete();
        m_tail = 1; m_full = 0; m_flush = 1; m_fpend = 0;
      end else begin
        do_commit = (mq.size() > 0) && mq[0].rdy_f;
        if (cdb_valid)
          foreach (mq[i]) if (mq[i].tag == int'(cdb_tag)) begin
            mq[i].rdy_f = 1; mq[i].data = cdb_data; mq[i].taken = cdb_br_taken;
          end
        if (alloc_valid && !m_full && !was_flush) begin
          e.tag = m_tail; e.rd = alloc_rd; e.is_br = alloc_is_br; e.pred = alloc_pred_taken;
          e.pc_alt = alloc_pc_alt; e.rdy_f = 0; e.taken = 0; e.data = 0;
          mq.push_back(e);
          m_tail = (m_tail == DEPTH) ? 1 : m_tail + 1;
        end
        if (do_commit) begin
          e = mq.pop_front();
          m_cv = 1; m_crd = e.rd; m_ctag = e.tag; m_cdata = e.data;
          if (e.is_br && (e.taken != e.pred)) begin
            m_fpend = 1;
            m_redir = e.pc_alt;
          end
        end
        m_full = (mq.size() == DEPTH);
      end
    end
  end

  // ---------------- per-cycle comparison against the model -----------------
  always @(negedge clk) begin : compare_p
    bit          r;
    logic [31:0] d;
    if (cmp_en) begin
      chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
      chk("full", 32'(full), 32'(m_full));
      chk("commit_valid", 32'(commit_valid), 32'(m_cv));
      if (m_cv) begin
        chk("commit_rd", 32'(commit_rd), 32'(m_crd));
        chk("commit_tag", 32'(commit_tag), 32'(m_ctag));
        chk("commit_data", commit_data, m_cdata);
        $display("commit tag=%0d rd=%0d data=0x%h", commit_tag, commit_rd, commit_data);
      end
      chk("flush", 32'(flush), 32'(m_flush));
      if (m_flush) begin
        chk("redirect_pc", redirect_pc, m_redir);
        $display("flush redirect_pc=0x%h", redirect_pc);
      end
      lookup(q1_tag, r, d);
      chk("q1_ready", 32'(q1_ready), 32'(r));
      if (r) chk("q1_data", q1_data, d);
      lookup(q2_tag, r, d);
      chk("q2_ready", 32'(q2_ready), 32'(r));
      if (r) chk("q2_data", q2_data, d);
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; cdb_valid = 0; q1_tag = 0; q2_tag = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; rdy = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic alloc(input logic [4:0] rd, input bit br, input bit pred, input logic [31:0] pc);
    alloc_valid = 1; alloc_rd = rd; alloc_is_br = br; alloc_pred_taken = pred; alloc_pc_alt = pc;
    tick();
    alloc_valid = 0;
  endtask

  task automatic wb(input int tag, input logic [31:0] d, input bit tk);
    cdb_valid = 1; cdb_tag = TAG_W'(tag); cdb_data = d; cdb_br_taken = tk;
    tick();
    cdb_valid = 0;
  endtask

  initial begin
    rst = 1; rdy = 1; idle();
    alloc_rd = 0; alloc_is_br = 0; alloc_pred_taken = 0; alloc_pc_alt = 0;
    cdb_tag = 0; cdb_data = 0; cdb_br_taken = 0;

    // 1: reset values, single alloc -> writeback -> commit
    do_reset();
    cmp_en = 1;
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_commit_rd", 32'(commit_rd), 32'd0);
    chk("rst_commit_tag", 32'(commit_tag), 32'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_q1_ready", 32'(q1_ready), 32'd0);
    alloc(5'd5, 0, 0, 32'd0);
    chk("t1_alloc_tag", 32'(alloc_tag), 32'd2);
    wb(1, 32'h2A, 0);
    chk("t1_no_early_commit", 32'(commit_valid), 32'd0);
    tick();
    chk("t1_commit_valid", 32'(commit_valid), 32'd1);
    chk("t1_commit_rd", 32'(commit_rd), 32'd5);
    chk("t1_commit_tag", 32'(commit_tag), 32'd1);
    chk("t1_commit_data", commit_data, 32'h2A);

    // 2: out-of-order writeback, in-order back-to-back commit
    do_reset();
    for (int i = 0; i < 3; i++) alloc(5'(i + 1), 0, 0, 32'd0);
    wb(3, 32'h303, 0);
    wb(2, 32'h202, 0);
    wb(1, 32'h101, 0);
    chk("t2_wait", 32'(commit_valid), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t2_commit_valid", 32'(commit_valid), 32'd1);
      chk("t2_commit_tag", 32'(commit_tag), 32'(i));
    end
    tick();
    chk("t2_drained", 32'(commit_valid), 32'd0);

    // 3: fill to full, dropped 17th alloc, commit one, tag 1 reused
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(5'(i), 0, 0, 32'd0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_wrap_tag", 32'(alloc_tag), 32'd1);
    alloc(5'd9, 0, 0, 32'd0);
    chk("t3_drop_full", 32'(full), 32'd1);
    chk("t3_drop_tag", 32'(alloc_tag), 32'd1);
    wb(1, 32'h11, 0);
    tick();
    chk("t3_commit_tag", 32'(commit_tag), 32'd1);
    chk("t3_not_full", 32'(full), 32'd0);
    chk("t3_reuse_tag", 32'(alloc_tag), 32'd1);
    alloc(5'd3, 0, 0, 32'd0);
    chk("t3_refull", 32'(full), 32'd1);
    chk("t3_next_tag", 32'(alloc_tag), 32'd2);

    // 4: mispredicted branch at head -> commit, then flush + redirect
    do_reset();
    alloc(5'd1, 1, 0, 32'h1000);
    for (int i = 0; i < 3; i++) alloc(5'(i + 2), 0, 0, 32'd0);
    wb(3, 32'h33, 0);
    wb(1, 32'h44, 1);
    tick();
    chk("t4_commit_valid", 32'(commit_valid), 32'd1);
    chk("t4_commit_tag", 32'(commit_tag), 32'd1);
    chk("t4_no_flush_yet", 32'(flush), 32'd0);
    tick();
    chk("t4_flush", 32'(flush), 32'd1);
    chk("t4_redirect_pc", redirect_pc, 32'h1000);
    chk("t4_flush_no_commit", 32'(commit_valid), 32'd0);
    chk("t4_alloc_tag", 32'(alloc_tag), 32'd1);
    tick();
    chk("t4_flush_done", 32'(flush), 32'd0);

    // 5: bypass lookup of a ready entry that is not at the head
    do_reset();
    for (int i = 0; i < 3; i++) alloc(5'(i + 1), 0, 0, 32'd0);
    wb(3, 32'h77, 0);
    q1_tag = 3; q2_tag = 1;
    #1;
`ifdef ROB_BYPASS_EN
    chk("t5_q1_ready", 32'(q1_ready), 32'd1);
    chk("t5_q1_data", q1_data, 32'h77);
`else
    chk("t5_q1_ready", 32'(q1_ready), 32'd0);
    chk("t5_q1_data", q1_data, 32'd0);
`endif
    chk("t5_q2_ready", 32'(q2_ready), 32'd0);
    q1_tag = 0; q2_tag = 0;

    // 6: reset with live entries; stale writeback afterwards is ignored
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1), 0, 0, 32'd0);
    wb(2, 32'h22, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_commit_valid", 32'(commit_valid), 32'd0);
    chk("t6_flush", 32'(flush), 32'd0);
    chk("t6_alloc_tag", 32'(alloc_tag), 32'd1);
    wb(1, 32'h55, 0);
    alloc(5'd7, 0, 0, 32'd0);
    alloc(5'd8, 0, 0, 32'd0);
    q1_tag = 1;
    tick();
    chk("t6_stale_ready", 32'(q1_ready), 32'd0);
    chk("t6_stale_commit", 32'(commit_valid), 32'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int cand[$];
      int t;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 599) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_rd = 5'($urandom);
      alloc_is_br = ($urandom_range(0, 5) == 0);
      alloc_pred_taken = 1'($urandom);
      alloc_pc_alt = $urandom;
      cdb_data = $urandom;
      cdb_br_taken = 1'($urandom);
      cdb_valid = 0;
      cand.delete();
      foreach (mq[i]) if (!mq[i].rdy_f) cand.push_back(mq[i].tag);
      if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
        cdb_valid = 1;
        cdb_tag = TAG_W'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 3) == 0) begin
        t = $urandom_range(0, 31);
        while (is_live(t)) t = (t + 1) % 32;
        cdb_valid = 1;
        cdb_tag = TAG_W'(t);
      end
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        q1_tag = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        q1_tag = TAG_W'($urandom_range(0, 31));
      q2_tag = TAG_W'($urandom_range(0, 17));
    end
    idle();
    rst = 0; rdy = 1;
    tick();
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
